// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-seg driver: frame-synchronous double buffer, leading-zero blanking, 8-level PWM.
// Pins lag scan state by one cycle; no backpressure, a load is acknowledged at the next frame boundary.
module seg7_scan #(
    parameter int NDIG      = 8,
    parameter int SCAN_LOG2 = 15
) (
    input  logic              CLK100MHZ,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] data,
    input  logic              load,
    input  logic [NDIG-1:0]   dp,
    input  logic              lzb_en,
    input  logic [2:0]        bright,
    output logic [6:0]        seg,
    output logic              dp_n,
    output logic [NDIG-1:0]   an,
    output logic              load_ack,
    output logic              frame_tick
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    logic [SCAN_LOG2-1:0] p;
    logic [IW-1:0]        idx;
    logic [4*NDIG-1:0]    staging;
    logic [NDIG-1:0]      staging_dp;
    logic [4*NDIG-1:0]    shadow;
    logic [NDIG-1:0]      shadow_dp;
    logic                 pending;

    logic                 slot_end;
    logic                 boundary;
    logic                 lit;
    logic                 nz;
    logic [NDIG-1:0]      blank_vec;
    logic                 show;
    logic [3:0]           cur_nib;
    logic [NDIG-1:0]      an_nxt;

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h40;
            4'h1: enc = 7'h79;
            4'h2: enc = 7'h24;
            4'h3: enc = 7'h30;
            4'h4: enc = 7'h19;
            4'h5: enc = 7'h12;
            4'h6: enc = 7'h02;
            4'h7: enc = 7'h78;
            4'h8: enc = 7'h00;
            4'h9: enc = 7'h10;
            4'hA: enc = 7'h08;
            4'hB: enc = 7'h03;
            4'hC: enc = 7'h46;
            4'hD: enc = 7'h21;
            4'hE: enc = 7'h06;
            4'hF: enc = 7'h0E;
        endcase
    endfunction

    assign slot_end = &p;
    assign boundary = slot_end && (idx == LAST);
    assign lit      = (p[SCAN_LOG2-1 -: 3] <= bright);
    assign cur_nib  = shadow[{idx, 2'b00} +: 4];

    // Scan from the top digit down; a digit is blank while nothing above or at it is nonzero.
    always_comb begin
        nz        = 1'b0;
        blank_vec = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            nz           = nz | (shadow[4*i +: 4] != 4'h0);
            blank_vec[i] = lzb_en && (i != 0) && !nz;
        end
    end

    assign show = lit && !blank_vec[idx];

    always_comb begin
        an_nxt = '1;
        if (show) begin
            an_nxt[idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            p          <= '0;
            idx        <= '0;
            staging    <= '0;
            staging_dp <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            p          <= p + 1'b1;
            frame_tick <= boundary;
            load_ack   <= 1'b0;
            if (slot_end) begin
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            if (load) begin
                staging    <= data;
                staging_dp <= dp;
            end
            // A load in the boundary cycle bypasses staging so it is not lost a whole frame.
            if (boundary && (pending || load)) begin
                shadow    <= load ? data : staging;
                shadow_dp <= load ? dp : staging_dp;
                pending   <= 1'b0;
                load_ack  <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            seg  <= 7'h7F;
            dp_n <= 1'b1;
            an   <= '1;
        end else begin
            seg  <= blank_vec[idx] ? 7'h7F : enc(cur_nib);
            dp_n <= ~(show && shadow_dp[idx]);
            an   <= an_nxt;
        end
    end
endmodule
